// File: rtl/eeprom_test_ctrl.sv
// eeprom_test_ctrl: writes an address-derived pattern to an EEPROM through an I2C engine,
// reads it back and reports pass/fail, first miscompare and engine timeout.
module eeprom_test_ctrl #(
  parameter int         NUM_BYTES      = 16,
  parameter logic [7:0] START_ADDR     = 8'h00,
  parameter int         TWR_CYCLES     = 250000,
  parameter int         TIMEOUT_CYCLES = 2000000,
  parameter logic [7:0] PATTERN        = 8'h5A
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       go,
  output logic [1:0] start_sig,
  output logic [7:0] addr_sig,
  output logic [7:0] wrdata,
  input  logic [7:0] rddata,
  input  logic       done_sig,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic       timeout_err,
  output logic [7:0] err_addr,
  output logic [7:0] err_data
);
  localparam int TMAX = (TWR_CYCLES > TIMEOUT_CYCLES) ? TWR_CYCLES : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [7:0] LAST = 8'(NUM_BYTES - 1);
  localparam logic [TW-1:0] GAP_END = TW'(TWR_CYCLES - 1);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_CMP, DONE} state_e;
  state_e state_q, state_d;
  logic [7:0] addr_q, addr_d, wrdata_q, wrdata_d, cnt_q, cnt_d, rd_q, rd_d;
  logic [7:0] err_addr_q, err_addr_d, err_data_q, err_data_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic pass_q, pass_d, fail_q, fail_d, to_q, to_d;
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wrdata_q   <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      tmr_q      <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wrdata_q   <= wrdata_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      tmr_q      <= tmr_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      to_q       <= to_d;
    end
  end
  // tmr_q is shared: request wait budget in *_REQ, write-recovery gap in WR_GAP
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wrdata_d   = wrdata_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    tmr_d      = '0;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    to_d       = to_q;
    case (state_q)
      IDLE: if (go) begin
        state_d    = WR_REQ;
        addr_d     = START_ADDR;
        wrdata_d   = START_ADDR ^ PATTERN;
        cnt_d      = '0;
        err_addr_d = '0;
        err_data_d = '0;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        to_d       = 1'b0;
      end
      WR_REQ, RD_REQ: if (done_sig) begin
        state_d = (state_q == WR_REQ) ? WR_GAP : RD_CMP;
        rd_d    = (state_q == RD_REQ) ? rddata : rd_q;
      end else if (tmr_q == TO_END) begin
        state_d    = DONE;
        to_d       = 1'b1;
        fail_d     = 1'b1;
        err_addr_d = addr_q;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      WR_GAP: if (tmr_q != GAP_END) begin
        tmr_d = tmr_q + 1'b1;
      end else if (cnt_q == LAST) begin
        state_d  = RD_REQ;
        cnt_d    = '0;
        addr_d   = START_ADDR;
        wrdata_d = START_ADDR ^ PATTERN;
      end else begin
        state_d  = WR_REQ;
        cnt_d    = cnt_q + 8'd1;
        addr_d   = addr_q + 8'd1;
        wrdata_d = (addr_q + 8'd1) ^ PATTERN;
      end
      RD_CMP: if (rd_q != (addr_q ^ PATTERN)) begin
        state_d    = DONE;
        fail_d     = 1'b1;
        err_addr_d = addr_q;
        err_data_d = rd_q;
      end else if (cnt_q == LAST) begin
        state_d = DONE;
        pass_d  = 1'b1;
      end else begin
        state_d  = RD_REQ;
        cnt_d    = cnt_q + 8'd1;
        addr_d   = addr_q + 8'd1;
        wrdata_d = (addr_q + 8'd1) ^ PATTERN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    start_sig   = (state_q == WR_REQ) ? 2'b01 : (state_q == RD_REQ) ? 2'b10 : 2'b00;
    busy        = !(state_q == IDLE || state_q == DONE);
    addr_sig    = addr_q;
    wrdata      = wrdata_q;
    pass        = pass_q;
    fail        = fail_q;
    timeout_err = to_q;
    err_addr    = err_addr_q;
    err_data    = err_data_q;
  end
endmodule

// File: tb/tb_eeprom_test_ctrl.sv
// tb_eeprom_test_ctrl: random-latency echo EEPROM engine with optional read corruption,
// results checked against a transaction-list model of the write/read-back test.
module tb_eeprom_test_ctrl;
  localparam logic [7:0] SA = 8'hFE;
  localparam int N = 4;
  localparam logic [7:0] PAT = 8'h5A;
  logic sysclk = 1'b0, rst_n = 1'b0, go = 1'b0, done_sig = 1'b0;
  logic [7:0] rddata = '0;
  logic [1:0] start_sig;
  logic [7:0] addr_sig, wrdata, err_addr, err_data;
  logic busy, pass, fail, timeout_err;
  int errors = 0, checks = 0;
  bit ack_en = 1'b1;
  int corrupt = -1;
  logic [7:0] cval = '0;
  int ecnt = 0, lat = 0, wr_cycles = 0;
  logic [7:0] mem [256];
  logic [16:0] log_q [$];
  logic [16:0] exp_q [$];

  eeprom_test_ctrl #(.NUM_BYTES(N), .START_ADDR(SA), .TWR_CYCLES(10),
                     .TIMEOUT_CYCLES(100), .PATTERN(PAT)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .go(go), .start_sig(start_sig), .addr_sig(addr_sig),
    .wrdata(wrdata), .rddata(rddata), .done_sig(done_sig), .busy(busy), .pass(pass),
    .fail(fail), .timeout_err(timeout_err), .err_addr(err_addr), .err_data(err_data));

  always #10 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // engine: acknowledges each request after a random latency, memory echoes writes
  initial begin
    forever begin
      @(negedge sysclk);
      if (done_sig) chk("idle_between_txn", {30'd0, start_sig}, 0);
      done_sig = 1'b0;
      if (start_sig == 2'b01) wr_cycles++;
      if (!rst_n || start_sig == 2'b00 || !ack_en) begin
        ecnt = 0;
      end else if (ecnt < lat) begin
        ecnt++;
      end else begin
        done_sig = 1'b1;
        ecnt = 0;
        lat = $urandom_range(0, 4);
        if (start_sig == 2'b01) begin
          mem[addr_sig] = wrdata;
          log_q.push_back({1'b0, addr_sig, wrdata});
        end else begin
          rddata = (corrupt >= 0 && addr_sig == corrupt[7:0]) ? cval : mem[addr_sig];
          log_q.push_back({1'b1, addr_sig, rddata});
        end
      end
    end
  end

  task automatic run(input bit ack, input int cidx, input logic [7:0] cv, input bit mid_go);
    logic [7:0] a, v, eaddr, edata;
    bit epass, efail;
    epass = 0; efail = 0; eaddr = 0; edata = 0;
    exp_q.delete();
    corrupt = (cidx < 0) ? -1 : int'(8'(SA + 8'(cidx)));
    if (ack) begin
      for (int i = 0; i < N; i++) begin
        a = 8'(SA + 8'(i));
        exp_q.push_back({1'b0, a, a ^ PAT});
      end
      for (int i = 0; i < N && !efail; i++) begin
        a = 8'(SA + 8'(i));
        v = (corrupt >= 0 && int'(a) == corrupt) ? cv : (a ^ PAT);
        exp_q.push_back({1'b1, a, v});
        if (v != (a ^ PAT)) begin efail = 1; eaddr = a; edata = v; end
      end
      epass = !efail;
    end else begin
      efail = 1; eaddr = SA;
    end
    ack_en = ack; cval = cv; wr_cycles = 0;
    log_q.delete();
    @(negedge sysclk); go = 1'b1;
    @(negedge sysclk); go = 1'b0;
    chk("busy_on_go", {31'd0, busy}, 1);
    chk("flags_cleared", {29'd0, pass, fail, timeout_err}, 0);
    chk("first_addr", {24'd0, addr_sig}, {24'd0, SA});
    if (mid_go) begin
      for (int i = 0; i < 200 && log_q.size() == 0; i++) @(negedge sysclk);
      chk("first_write_seen", log_q.size(), 1);
      repeat (2) @(negedge sysclk);
      go = 1'b1;
      @(negedge sysclk); go = 1'b0;
      chk("go_ignored_busy", {31'd0, busy}, 1);
      chk("go_ignored_addr", {24'd0, addr_sig}, {24'd0, SA});
    end
    for (int i = 0; i < 5000 && busy; i++) @(negedge sysclk);
    chk("test_ends", {31'd0, busy}, 0);
    chk("txn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) chk("txn", {15'd0, log_q[i]}, {15'd0, exp_q[i]});
    chk("pass", {31'd0, pass}, {31'd0, epass});
    chk("fail", {31'd0, fail}, {31'd0, efail});
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, !ack});
    chk("err_addr", {24'd0, err_addr}, {24'd0, eaddr});
    chk("err_data", {24'd0, err_data}, {24'd0, edata});
    chk("start_idle", {30'd0, start_sig}, 0);
    if (!ack) chk("timeout_len", wr_cycles, 100);
    @(negedge sysclk);
    chk("flags_persist", {30'd0, pass, fail}, {30'd0, epass, efail});
  endtask

  initial begin
    repeat (3) @(negedge sysclk);
    chk("rst_start", {30'd0, start_sig}, 0);
    chk("rst_addr", {24'd0, addr_sig}, 0);
    chk("rst_wrdata", {24'd0, wrdata}, 0);
    chk("rst_flags", {28'd0, busy, pass, fail, timeout_err}, 0);
    chk("rst_err", {16'd0, err_addr, err_data}, 0);
    rst_n = 1'b1;
    @(negedge sysclk);
    run(1, -1, 8'h00, 0);
    run(1, 2, 8'h00, 0);
    run(1, -1, 8'h00, 1);
    run(0, -1, 8'h00, 0);
    for (int k = 0; k < 6; k++) begin
      int ci;
      ci = $urandom_range(0, 5);
      run(1, (ci < N) ? ci : -1, 8'($urandom_range(0, 255)), 0);
    end
    ack_en = 1'b1; corrupt = -1;
    @(negedge sysclk); go = 1'b1;
    @(negedge sysclk); go = 1'b0;
    for (int i = 0; i < 1000 && start_sig != 2'b10; i++) @(negedge sysclk);
    chk("read_phase_reached", {30'd0, start_sig}, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_start", {30'd0, start_sig}, 0);
    chk("arst_addr", {24'd0, addr_sig}, 0);
    chk("arst_wrdata", {24'd0, wrdata}, 0);
    chk("arst_flags", {28'd0, busy, pass, fail, timeout_err}, 0);
    chk("arst_err", {16'd0, err_addr, err_data}, 0);
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (20) @(negedge sysclk);
    chk("no_resume_start", {30'd0, start_sig}, 0);
    chk("no_resume_busy", {31'd0, busy}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/eeprom_test_ctrl.md
EEPROM_TEST_CTRL -- requirements
Module: eeprom_test_ctrl

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 16, number of bytes written then read back (legal 1..256).
REQ-002 SHALL have parameter START_ADDR, default 8'h00, first EEPROM word address.
REQ-003 SHALL have parameter TWR_CYCLES, default 250000, post-write idle gap in sysclk cycles (5 ms at 50 MHz).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2000000, maximum cycles to wait for done_sig per transaction.
REQ-005 SHALL have parameter PATTERN, default 8'h5A, XOR mask for test data.
REQ-006 SHALL have port sysclk  input  1  system clock (50 MHz); all logic on the rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port go  input  1  single-cycle test start request.
REQ-009 SHALL have port start_sig  output  2  I2C command to the I2C engine: 01 write, 10 read, 00 idle.
REQ-010 SHALL have port addr_sig  output  8  EEPROM word address of the current transaction.
REQ-011 SHALL have port wrdata  output  8  byte to write.
REQ-012 SHALL have port rddata  input  8  byte returned by the engine, valid when done_sig=1.
REQ-013 SHALL have port done_sig  input  1  one-cycle transaction-complete pulse from the engine.
REQ-014 SHALL have port busy  output  1  test in progress.
REQ-015 SHALL have ports pass, fail, timeout_err  output  1 each  sticky result flags.
REQ-016 SHALL have ports err_addr, err_data  output  8 each  address and read value of the first miscompare.

Function
REQ-017 SHALL implement states IDLE, WR_REQ, WR_GAP, RD_REQ, RD_CMP, DONE.
REQ-018 IDLE: on go=1, SHALL clear pass/fail/timeout_err/err_addr/err_data, load addr_sig=START_ADDR, clear byte counter, and enter WR_REQ next cycle; busy=1 from that cycle.
REQ-019 Expected data SHALL be addr_sig XOR PATTERN; in WR_REQ, wrdata SHALL equal this value.
REQ-020 WR_REQ SHALL hold start_sig=01 and hold addr_sig/wrdata stable until done_sig=1; start_sig SHALL be 00 on the following cycle.
REQ-021 On done_sig in WR_REQ, SHALL enter WR_GAP; WR_GAP SHALL last exactly TWR_CYCLES cycles with start_sig=00.
REQ-022 At WR_GAP end: if byte counter = NUM_BYTES-1, SHALL reset counter, set addr_sig=START_ADDR, enter RD_REQ; else counter+1, addr_sig+1, enter WR_REQ.
REQ-023 RD_REQ SHALL hold start_sig=10 until done_sig=1, capturing rddata on that same edge; start_sig=00 next cycle, enter RD_CMP.
REQ-024 RD_CMP (one cycle): on mismatch SHALL set fail=1, err_addr=addr_sig, err_data=captured byte, enter DONE; on match with counter = NUM_BYTES-1, SHALL set pass=1, enter DONE; else counter+1, addr_sig+1, enter RD_REQ.
REQ-025 At least one cycle with start_sig=00 SHALL separate any two consecutive transactions.
REQ-026 addr_sig increment SHALL wrap modulo 256 (8'hFF -> 8'h00).
REQ-027 A wait counter SHALL run in WR_REQ and RD_REQ; reaching TIMEOUT_CYCLES without done_sig SHALL set timeout_err=1 and fail=1, err_addr=addr_sig, start_sig=00, enter DONE.
REQ-028 DONE SHALL drive busy=0 and return to IDLE next cycle; flags SHALL persist until next accepted go.
REQ-029 go while busy=1 SHALL be ignored.
REQ-030 done_sig outside WR_REQ/RD_REQ SHALL be ignored.
REQ-031 pass and fail SHALL never be 1 simultaneously.

Reset
REQ-032 On rst_n=0, SHALL asynchronously enter IDLE with start_sig=00, addr_sig=0, wrdata=0, busy=0, pass=0, fail=0, timeout_err=0, err_addr=0, err_data=0, counters=0.
REQ-033 Reset mid-transaction SHALL force start_sig=00 immediately; no resumption after release.

Verification
REQ-034 Engine model ACKs all, memory echoes; NUM_BYTES=4, TWR_CYCLES=10 -> writes 0x5A,0x5B,0x58,0x59 at 0..3, reads match, pass=1, busy=0.
REQ-035 Model corrupts address 2 read to 0x00 -> fail=1, err_addr=0x02, err_data=0x00, no read of address 3.
REQ-036 START_ADDR=8'hFE, NUM_BYTES=3 -> addresses FE, FF, 00 in both phases, pass=1.
REQ-037 Model never asserts done_sig, TIMEOUT_CYCLES=100 -> timeout_err=1, fail=1, err_addr=START_ADDR, start_sig=00 after 100 cycles.
REQ-038 go pulsed during WR_GAP, and rst_n low during RD_REQ -> go ignored; reset gives start_sig=00 and all outputs at reset values.
